// File: rtl/la_capture_core.sv
// la_capture_core: logic-analyser capture engine with circular pre-trigger
// buffer, masked level/edge trigger and oldest-first valid/ready readout.
// Ports: sys_clk/sys_rst_n; data_i probes; trig_i/trig_mask_i/trig_value_i/
// trig_edge_i trigger config; pretrig_i pre-trigger depth; arm_i/abort_i
// control; rd_valid_o/rd_ready_i/rd_data_o/rd_last_o readout stream;
// state_o (0 IDLE,1 PRE,2 WAIT,3 POST,4 DONE); triggered_o.
// Option: define LA_TRIG_COUNT_EN to add trig_cnt_i (fire on the N+1-th match).
module la_capture_core #(
  parameter int DATA_W = 9,
  parameter int TRIG_W = 1,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic [TRIG_W-1:0] trig_mask_i,
  input  logic [TRIG_W-1:0] trig_value_i,
  input  logic              trig_edge_i,
  input  logic [ADDR_W-1:0] pretrig_i,
  input  logic              arm_i,
  input  logic              abort_i,
`ifdef LA_TRIG_COUNT_EN
  input  logic [7:0]        trig_cnt_i,
`endif
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_last_o,
  output logic [2:0]        state_o,
  output logic              triggered_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t state_q, state_d;

  logic [TRIG_W-1:0] mask_q;
  logic [TRIG_W-1:0] value_q;
  logic              edge_q;
  logic [ADDR_W-1:0] pretrig_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W:0]   post_cnt;
  logic [ADDR_W:0]   post_need;
  logic              match_q;

  logic [ADDR_W:0]   issue_cnt;
  logic [ADDR_W-1:0] rd_start;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] ram_q;
  logic              ram_q_vld;
  logic              ram_q_last;

  logic [DATA_W-1:0] mem [DEPTH];

  logic match;
  logic match_arm;
  logic fire;
  logic take;
  logic arm_ok;
  logic we;
  logic out_load;
  logic q_take;
  logic issue;
  logic last_beat;

  assign match     = ((trig_i ^ value_q) & mask_q) == '0;
  // Edge history must reflect the new config on the arm cycle, otherwise
  // a stale mask could fake a rising edge on the first WAIT cycle.
  assign match_arm = ((trig_i ^ trig_value_i) & trig_mask_i) == '0;
  assign fire      = edge_q ? (match & ~match_q) : match;

`ifdef LA_TRIG_COUNT_EN
  logic [7:0] cnt_q;
  logic [7:0] fire_cnt;
  assign take = fire & (fire_cnt == cnt_q);
`else
  assign take = fire;
`endif

  assign arm_ok = arm_i & ~abort_i &
                  ((state_q == S_IDLE) | (state_q == S_DONE));
  assign we = (state_q == S_PRE) | (state_q == S_WAIT) |
              (state_q == S_POST);

  assign post_need = DEPTH_L - {1'b0, pretrig_q};

  // Readout: one-entry RAM output register feeding the output register.
  assign rd_start  = trig_addr - pretrig_q;
  assign rd_addr   = rd_start + issue_cnt[ADDR_W-1:0];
  assign out_load  = (state_q == S_DONE) & (~rd_valid_o | rd_ready_i);
  assign q_take    = out_load & ram_q_vld;
  assign issue     = (state_q == S_DONE) & ~issue_cnt[ADDR_W] &
                     (~ram_q_vld | q_take);
  assign last_beat = rd_valid_o & rd_ready_i & rd_last_o;

  assign state_o = state_q;

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else if (arm_ok) begin
      state_d = (pretrig_i == '0) ? S_WAIT : S_PRE;
    end else begin
      unique case (state_q)
        S_PRE: begin
          if (wr_ptr == pretrig_q - 1'b1)
            state_d = S_WAIT;
        end
        S_WAIT: begin
          if (take)
            state_d = (post_need == 1) ? S_DONE : S_POST;
        end
        S_POST: begin
          if (post_cnt + 1'b1 == post_need)
            state_d = S_DONE;
        end
        S_DONE: begin
          if (last_beat)
            state_d = S_IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      value_q     <= '0;
      edge_q      <= 1'b0;
      pretrig_q   <= '0;
      wr_ptr      <= '0;
      trig_addr   <= '0;
      post_cnt    <= '0;
      match_q     <= 1'b0;
      issue_cnt   <= '0;
      ram_q_vld   <= 1'b0;
      ram_q_last  <= 1'b0;
      rd_valid_o  <= 1'b0;
      rd_data_o   <= '0;
      rd_last_o   <= 1'b0;
      triggered_o <= 1'b0;
`ifdef LA_TRIG_COUNT_EN
      cnt_q       <= '0;
      fire_cnt    <= '0;
`endif
    end else begin
      state_q <= state_d;
      match_q <= arm_ok ? match_arm : match;
      if (abort_i) begin
        rd_valid_o <= 1'b0;
        rd_last_o  <= 1'b0;
        ram_q_vld  <= 1'b0;
`ifdef LA_TRIG_COUNT_EN
        fire_cnt   <= '0;
`endif
      end else if (arm_ok) begin
        mask_q      <= trig_mask_i;
        value_q     <= trig_value_i;
        edge_q      <= trig_edge_i;
        pretrig_q   <= pretrig_i;
        wr_ptr      <= '0;
        triggered_o <= 1'b0;
        issue_cnt   <= '0;
        ram_q_vld   <= 1'b0;
        rd_valid_o  <= 1'b0;
        rd_last_o   <= 1'b0;
`ifdef LA_TRIG_COUNT_EN
        cnt_q       <= trig_cnt_i;
        fire_cnt    <= '0;
`endif
      end else begin
        if (we)
          wr_ptr <= wr_ptr + 1'b1;
        if (state_q == S_WAIT && take) begin
          trig_addr   <= wr_ptr;
          triggered_o <= 1'b1;
          post_cnt    <= (ADDR_W+1)'(1);
        end
`ifdef LA_TRIG_COUNT_EN
        if (state_q == S_WAIT && fire && !take)
          fire_cnt <= fire_cnt + 1'b1;
`endif
        if (state_q == S_POST)
          post_cnt <= post_cnt + 1'b1;
        if (issue) begin
          issue_cnt  <= issue_cnt + 1'b1;
          ram_q_vld  <= 1'b1;
          ram_q_last <= &issue_cnt[ADDR_W-1:0];
        end else if (q_take) begin
          ram_q_vld <= 1'b0;
        end
        if (out_load) begin
          if (q_take) begin
            rd_valid_o <= 1'b1;
            rd_data_o  <= ram_q;
            rd_last_o  <= ram_q_last;
          end else begin
            rd_valid_o <= 1'b0;
            rd_last_o  <= 1'b0;
          end
        end
      end
    end
  end

  // Buffer RAM: no reset so it maps onto block RAM.
  always_ff @(posedge sys_clk) begin
    if (we)
      mem[wr_ptr] <= data_i;
    if (issue)
      ram_q <= mem[rd_addr];
  end

endmodule
